// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI initiator.
package spi_pkg;

    localparam int unsigned SPI_BYTE_W  = 8;
    localparam int unsigned MIN_CLK_DIV = 4;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StXfer,
        StWait,
        StHold,
        StGap
    } spi_state_e;

endpackage

// File: rtl/spi_master_if.sv
// Four-wire SPI link between an initiator (master) and a target (slave).
interface spi_master_if;

    logic ss;
    logic sck;
    logic mosi;
    logic miso;

    modport master (output ss, output sck, output mosi, input miso);
    modport slave  (input ss, input sck, input mosi, output miso);

endinterface

// File: rtl/spi_sck_gen.sv
// Half-period divider producing sck plus rise/fall strobes; idle and cleared while en is low.
module spi_sck_gen #(
    parameter int unsigned CLK_DIV = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sck,
    output logic rise,
    output logic fall
);

    localparam int unsigned CW = $clog2(CLK_DIV) + 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sck_q, sck_d;
    logic          term;

    assign term = en && (cnt_q == CW'(CLK_DIV - 1));
    // Strobes coincide with the clk edge that changes sck_q.
    assign rise = term && !sck_q;
    assign fall = term && sck_q;
    assign sck  = sck_q;

    always_comb begin
        cnt_d = cnt_q;
        sck_d = sck_q;
        if (!en) begin
            cnt_d = '0;
            sck_d = 1'b0;
        end else if (term) begin
            cnt_d = '0;
            sck_d = !sck_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sck_q <= sck_d;
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 initiator, MSB first, with multi-byte frames held open by cont.
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 8,
    parameter int unsigned SS_SETUP = 8,
    parameter int unsigned SS_HOLD  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  cont,
    input  logic                  stop,
    input  logic [SPI_BYTE_W-1:0] din,
    output logic [SPI_BYTE_W-1:0] dout,
    output logic                  done,
    output logic                  busy,
    spi_master_if.master          bus
);

    localparam int unsigned CNT_MAX = (SS_SETUP > SS_HOLD) ? SS_SETUP : SS_HOLD;
    localparam int unsigned CW      = $clog2(CNT_MAX) + 1;

    if (CLK_DIV < MIN_CLK_DIV) begin : g_clk_div_check
        $error("spi_master: CLK_DIV below the minimum the slave can track");
    end

    spi_state_e            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [SPI_BYTE_W-1:0] tx_q, tx_d, rx_q, rx_d, dout_q, dout_d;
    logic [2:0]            bits_q, bits_d;
    logic                  cont_q, cont_d, done_q, done_d, busy_q, busy_d;
    logic                  ss_q, ss_d, mosi_q, mosi_d;
    logic                  sck, sck_rise, sck_fall;

    spi_sck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q == StXfer),
        .sck  (sck),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        tx_d    = tx_q;
        rx_d    = rx_q;
        bits_d  = bits_q;
        cont_d  = cont_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
        ss_d    = ss_q;
        mosi_d  = mosi_q;

        unique case (state_q)
            StIdle, StWait: begin
                cnt_d = '0;
                if (start) begin
                    tx_d    = din;
                    cont_d  = cont;
                    mosi_d  = din[SPI_BYTE_W-1];
                    bits_d  = '0;
                    ss_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = StSetup;
                end else if (stop && state_q == StWait) begin
                    busy_d  = 1'b1;
                    state_d = StHold;
                end
            end
            StSetup: begin
                if (cnt_q == CW'(SS_SETUP - 1)) begin
                    cnt_d   = '0;
                    state_d = StXfer;
                end
            end
            StXfer: begin
                cnt_d = '0;
                if (sck_rise) begin
                    rx_d   = {rx_q[SPI_BYTE_W-2:0], bus.miso};
                    bits_d = bits_q + 3'd1;
                end
                // bits_q wraps to zero after the eighth rise, so this fall closes the byte.
                if (sck_fall) begin
                    if (bits_q == 3'd0) begin
                        dout_d  = rx_q;
                        done_d  = 1'b1;
                        busy_d  = !cont_q;
                        state_d = cont_q ? StWait : StHold;
                    end else begin
                        tx_d   = {tx_q[SPI_BYTE_W-2:0], 1'b0};
                        mosi_d = tx_q[SPI_BYTE_W-2];
                    end
                end
            end
            StHold: begin
                if (cnt_q == CW'(SS_HOLD - 1)) begin
                    cnt_d   = '0;
                    ss_d    = 1'b1;
                    state_d = StGap;
                end
            end
            StGap: begin
                if (cnt_q == CW'(SS_HOLD - 1)) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            bits_q  <= '0;
            cont_q  <= 1'b0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ss_q    <= 1'b1;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            bits_q  <= bits_d;
            cont_q  <= cont_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ss_q    <= ss_d;
            mosi_q  <= mosi_d;
        end
    end

    assign dout     = dout_q;
    assign done     = done_q;
    assign busy     = busy_q;
    assign bus.ss   = ss_q;
    assign bus.sck  = sck;
    assign bus.mosi = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: behavioural SPI target, vector table, frame/stop/reset sequences, random bytes.
module tb_spi_master;
    import spi_pkg::*;

    localparam int unsigned CLK_DIV  = 8;
    localparam int unsigned SS_SETUP = 8;
    localparam int unsigned SS_HOLD  = 8;
    // Cycle counts with the start cycle counted as 1.
    localparam int T_DONE = 1 + SS_SETUP + 16 * CLK_DIV;
    localparam int T_SS   = T_DONE + SS_HOLD;
    localparam int T_BUSY = T_DONE + 2 * SS_HOLD;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0, cont = 1'b0, stop = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       done, busy;

    spi_master_if bus ();

    spi_master #(
        .CLK_DIV  (CLK_DIV),
        .SS_SETUP (SS_SETUP),
        .SS_HOLD  (SS_HOLD)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .cont  (cont),
        .stop  (stop),
        .din   (din),
        .dout  (dout),
        .done  (done),
        .busy  (busy),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Behavioural target: shifts out its queued byte MSB first, captures mosi on sck rise.
    logic [7:0] s_txq[$];
    logic [7:0] s_rxq[$];
    logic [7:0] s_tx = 8'h00, s_rx = 8'h00;
    int         s_cnt = 0;
    bit         s_have = 1'b0;
    int         miso_mode = 0;
    logic       sck_prev = 1'b0, ss_prev = 1'b1, done_prev = 1'b0;
    int         rises = 0, ss_rises = 0, mosi_ones = 0, done_cnt = 0;

    always @(negedge clk) begin
        if (bus.sck === 1'b1 && sck_prev === 1'b0) begin
            rises++;
            check("sck_while_ss_high", bus.ss, 1'b0);
            if (bus.mosi === 1'b1) mosi_ones++;
            s_rx = {s_rx[6:0], bus.mosi};
            s_cnt++;
            if (s_cnt == 8) begin
                s_rxq.push_back(s_rx);
                s_cnt  = 0;
                s_have = 1'b0;
            end
        end
        if (bus.ss === 1'b1 && ss_prev === 1'b0) ss_rises++;
        if (bus.ss !== 1'b0) begin
            s_cnt  = 0;
            s_have = 1'b0;
        end else if (!s_have && s_txq.size() > 0) begin
            s_tx   = s_txq.pop_front();
            s_have = 1'b1;
        end
        case (miso_mode)
            0:       bus.miso = s_have ? s_tx[3'(7 - s_cnt)] : 1'b0;
            1:       bus.miso = 1'b1;
            default: bus.miso = ~bus.sck;
        endcase
        if (done === 1'b1) begin
            done_cnt++;
            check("done_single_cycle", done_prev, 1'b0);
        end
        sck_prev  = bus.sck;
        ss_prev   = bus.ss;
        done_prev = done;
    end

    task automatic send(input logic [7:0] d, input logic c, input logic [7:0] sb,
                        input int inject_t, output logic [7:0] got, output int t);
        s_txq.push_back(sb);
        din   = d;
        cont  = c;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t = 1;
        while (done !== 1'b1 && t < 1000) begin
            if (t == inject_t) begin
                start = 1'b1;
                din   = 8'hFF;
                cont  = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            t++;
        end
        start = 1'b0;
        if (t >= 1000) check("done_timeout", 32'(t), 32'(T_DONE));
        got = dout;
    endtask

    task automatic wait_idle(input int t0, output int t_ss, output int t_busy);
        int t = t0;
        t_ss = 0;
        while (busy === 1'b1 && t < t0 + 1000) begin
            @(posedge clk); #1;
            t++;
            if (bus.ss === 1'b1 && t_ss == 0) t_ss = t;
        end
        if (t >= t0 + 1000) check("busy_timeout", 32'(t), 32'(t0));
        t_busy = t;
    endtask

    task automatic check_srx(input string name, input logic [7:0] exp);
        if (s_rxq.size() == 0) begin
            check(name, 32'hDEAD, 32'(exp));
        end else begin
            check(name, 32'(s_rxq.pop_front()), 32'(exp));
        end
    endtask

    typedef struct {
        logic [7:0] din;
        logic [7:0] sb;
        logic [7:0] exp_dout;
        logic [7:0] exp_srx;
    } vec_t;

    vec_t vecs[4];

    initial begin
        logic [7:0] got, d, sb;
        logic       c;
        int         t, t_ss, t_busy, r0, d0;

        vecs[0] = '{din: 8'hA5, sb: 8'h3C, exp_dout: 8'h3C, exp_srx: 8'hA5};
        vecs[1] = '{din: 8'h00, sb: 8'hFF, exp_dout: 8'hFF, exp_srx: 8'h00};
        vecs[2] = '{din: 8'hFF, sb: 8'h00, exp_dout: 8'h00, exp_srx: 8'hFF};
        vecs[3] = '{din: 8'h81, sb: 8'h7E, exp_dout: 8'h7E, exp_srx: 8'h81};

        // Reset state
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_ss", bus.ss, 1'b1);
        check("rst_sck", bus.sck, 1'b0);
        check("rst_mosi", bus.mosi, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_dout", dout, 8'h00);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Standalone bytes from the table
        for (int i = 0; i < 4; i++) begin
            send(vecs[i].din, 1'b0, vecs[i].sb, 0, got, t);
            check("vec_dout", got, vecs[i].exp_dout);
            check("vec_t_done", 32'(t), 32'(T_DONE));
            wait_idle(t, t_ss, t_busy);
            check("vec_t_ss", 32'(t_ss), 32'(T_SS));
            check("vec_t_busy", 32'(t_busy), 32'(T_BUSY));
            check_srx("vec_slave_rx", vecs[i].exp_srx);
        end

        // Two-byte frame
        ss_rises = 0;
        send(8'h12, 1'b1, 8'hF0, 0, got, t);
        check("frame_dout0", got, 8'hF0);
        check("frame_t_done0", 32'(t), 32'(T_DONE));
        check("frame_wait_busy", busy, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("frame_wait_ss", bus.ss, 1'b0);
        check("frame_wait_sck", bus.sck, 1'b0);
        send(8'h34, 1'b0, 8'h0F, 0, got, t);
        check("frame_dout1", got, 8'h0F);
        check("frame_t_done1", 32'(t), 32'(T_DONE));
        wait_idle(t, t_ss, t_busy);
        check("frame_t_busy", 32'(t_busy), 32'(T_BUSY));
        check("frame_ss_rises", 32'(ss_rises), 32'd1);
        check_srx("frame_srx0", 8'h12);
        check_srx("frame_srx1", 8'h34);

        // Frame closed by stop; stop in IDLE is ignored
        send(8'h55, 1'b1, 8'hAA, 0, got, t);
        check("stop_dout", got, 8'hAA);
        r0 = rises;
        repeat (3) @(posedge clk);
        #1;
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        check("stop_busy", busy, 1'b1);
        wait_idle(0, t_ss, t_busy);
        check("stop_t_ss", 32'(t_ss), 32'(SS_HOLD));
        check("stop_t_busy", 32'(t_busy), 32'(2 * SS_HOLD));
        check("stop_no_sck", 32'(rises), 32'(r0));
        check_srx("stop_srx", 8'h55);
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        check("stop_idle_busy", busy, 1'b0);
        check("stop_idle_ss", bus.ss, 1'b1);

        // start while busy is dropped
        r0 = rises;
        send(8'h3C, 1'b0, 8'h96, 40, got, t);
        check("drop_dout", got, 8'h96);
        check("drop_t_done", 32'(t), 32'(T_DONE));
        wait_idle(t, t_ss, t_busy);
        check("drop_t_busy", 32'(t_busy), 32'(T_BUSY));
        repeat (20) @(posedge clk);
        #1;
        check("drop_no_second", busy, 1'b0);
        check("drop_rises", 32'(rises - r0), 32'd8);
        check_srx("drop_srx", 8'h3C);

        // Reset asserted at the fourth sck rise
        s_txq.push_back(8'h5A);
        din   = 8'hC3;
        cont  = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        r0 = rises;
        t  = 0;
        while (rises - r0 < 4 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("rst4_reached", 32'(rises - r0), 32'd4);
        rst = 1'b0;
        d0  = done_cnt;
        @(posedge clk); #1;
        rst = 1'b1;
        check("rst4_ss", bus.ss, 1'b1);
        check("rst4_sck", bus.sck, 1'b0);
        check("rst4_mosi", bus.mosi, 1'b0);
        check("rst4_busy", busy, 1'b0);
        check("rst4_dout", dout, 8'h00);
        repeat (20) @(posedge clk);
        #1;
        check("rst4_no_done", 32'(done_cnt), 32'(d0));
        s_txq.delete();
        s_rxq.delete();
        send(8'hC3, 1'b0, 8'h5A, 0, got, t);
        check("rst4_fresh_dout", got, 8'h5A);
        wait_idle(t, t_ss, t_busy);
        check_srx("rst4_fresh_srx", 8'hC3);

        // miso held high, then miso high only while sck is low
        miso_mode = 1;
        mosi_ones = 0;
        send(8'h00, 1'b0, 8'h00, 0, got, t);
        check("miso1_dout", got, 8'hFF);
        check("miso1_mosi_low", 32'(mosi_ones), 32'd0);
        wait_idle(t, t_ss, t_busy);
        miso_mode = 2;
        send(8'h00, 1'b0, 8'h00, 0, got, t);
        check("miso_edge_dout", got, 8'hFF);
        wait_idle(t, t_ss, t_busy);
        miso_mode = 0;
        s_rxq.delete();

        // Random bytes and frames
        for (int i = 0; i < 24; i++) begin
            d  = 8'($urandom);
            sb = 8'($urandom);
            c  = (i == 23) ? 1'b0 : 1'($urandom_range(0, 1));
            send(d, c, sb, 0, got, t);
            check("rnd_dout", got, sb);
            check("rnd_t_done", 32'(t), 32'(T_DONE));
            check("rnd_busy", busy, !c);
            if (!c) begin
                wait_idle(t, t_ss, t_busy);
                check("rnd_t_busy", 32'(t_busy), 32'(T_BUSY));
            end else begin
                repeat ($urandom_range(0, 5)) @(posedge clk);
                #1;
            end
            check_srx("rnd_srx", d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
SPI initiator, mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit bytes. Drives the same link the team's spi_slave block terminates: controller-side logic (sequencer or host-link bridge) pushes bytes in and gets the simultaneously received byte back. Supports multi-byte frames by holding ss low between bytes. Single clock domain.

Parameters:
CLK_DIV, 8, sck half-period in clk cycles; legal minimum 4 so the slave's input register and edge detect see every edge.
SS_SETUP, 8, clk cycles from ss falling to the first sck rising edge; also used between bytes of a frame.
SS_HOLD, 8, clk cycles from the last sck falling edge to ss rising; also the minimum ss-high gap before the next frame.

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-low
start  in  1  request one byte transfer; ignored while busy=1
cont  in  1  sampled with start; 1 = keep ss low after this byte
stop  in  1  in WAIT state only: close the open frame without sending a byte
din  in  8  byte to send; sampled with start
dout  out  8  last received byte; valid when done=1, held until the next done
done  out  1  one-cycle pulse on byte completion
busy  out  1  high from accepted start until the block can accept the next start
ss  out  1  slave select, active-low
sck  out  1  serial clock, idles low
mosi  out  1  serial data out
miso  in  1  serial data in (same clk domain; no synchroniser)

Behaviour:
- Reset (rst=0 at a clk edge): next cycle ss=1, sck=0, mosi=0, busy=0, done=0, dout=0, state=IDLE. Applies mid-transfer: the frame is abandoned and no done pulse occurs.
- All outputs are registered.
- IDLE: ss=1, sck=0, busy=0.
  - On start: latch din into the shift register and latch cont; next cycle mosi=din[7], ss=0, busy=1; go to SETUP.
- SETUP: ss low, sck low; count SS_SETUP cycles, then go to XFER.
- XFER:
  - The divider counts CLK_DIV cycles per half-period and toggles sck at each terminal count; 16 half-periods per byte.
  - Rising edge: the clk edge that sets sck=1 also shifts miso into the LSB of the receive register and increments the 3-bit bit count.
  - Falling edge: after rises 1-7, mosi takes the next TX bit.
  - After the 8th rise: the falling edge ends the byte. In that same cycle dout is loaded with the 8 received bits and done=1 for exactly one cycle. mosi holds its last bit.
- After XFER:
  - cont latched = 1: go to WAIT.
  - cont latched = 0: go to HOLD.
- WAIT: ss=0, sck=0, busy=0.
  - start: latch din and cont; busy=1; go to SETUP. ss is not raised.
  - stop (without start): go to HOLD.
  - start and stop together: start wins, stop is ignored.
- HOLD: busy=1, ss=0; count SS_HOLD cycles, then ss=1 and go to GAP.
- GAP: busy=1, ss=1; count SS_HOLD cycles, then go to IDLE.
- Timing: a standalone byte occupies 1 + SS_SETUP + 16*CLK_DIV + 2*SS_HOLD cycles from start to busy falling. Default parameters: 1 + 8 + 128 + 16 = 153 cycles.
- start while busy=1 is dropped, with no side effects on din/cont latches. stop outside WAIT is ignored.
- Counter widths: $clog2 of the largest count, plus one bit; no wrap is possible within a state.

Decomposition:
- Shared package spi_pkg:
  - state enum {IDLE, SETUP, XFER, WAIT, HOLD, GAP}
  - SPI_BYTE_W=8
  - localparam minimum CLK_DIV=4, with an elaboration-time check.
- One natural sub-module, spi_sck_gen: a half-period divider that emits rise/fall strobes and the sck level, enabled only in XFER, cleared on exit.

Test Plan:
- Loopback with the team's spi_slave block (slave din=8'h3C), master din=8'hA5, cont=0: slave dout=8'hA5 with its done pulse; master dout=8'h3C with done after 16*CLK_DIV XFER cycles; ss high again SS_HOLD cycles later; busy low 153 cycles after start.
- Two-byte frame: 8'h12 with cont=1, then 8'h34 with cont=0, against a slave returning 8'hF0 then 8'h0F:
  - ss stays low across both bytes; SS_SETUP cycles with sck low between bytes
  - two done pulses with dout 8'hF0 then 8'h0F.
- Frame closed by stop: byte 8'h55 with cont=1, then stop pulsed in WAIT -> ss rises after SS_HOLD cycles, no extra sck edges, returns to IDLE.
- start pulsed mid-XFER with din=8'hFF -> ignored: the in-flight byte completes unchanged and no second transfer starts.
- rst=0 asserted at the 4th sck rising edge -> next cycle ss=1, sck=0, mosi=0, busy=0, dout=0, and no done pulse. A fresh start after release transfers correctly.
- miso held at 1, din=8'h00 -> mosi low on every rising edge, dout=8'hFF; check miso is sampled on the clk edge that raises sck.
